// File: rtl/fetch_queue_pkg.sv
// Shared width helpers and the default line type for the line-write / word-read fetch queue.
package fetch_queue_pkg;

  localparam int DEF_DATA_WIDTH  = 32;
  localparam int DEF_LINE_WORDS  = 4;
  localparam int DEF_DEPTH_WORDS = 64;

  // Word-offset width within a line.
  function automatic int ow_f(input int line_words);
    return $clog2(line_words);
  endfunction

  // Word-pointer width including the wrap bit.
  function automatic int pw_f(input int depth_words);
    return $clog2(depth_words) + 1;
  endfunction

  typedef logic [DEF_LINE_WORDS-1:0][DEF_DATA_WIDTH-1:0] line_t;

endpackage

// File: rtl/fq_line_ram.sv
// Register-array storage: one line-wide write port at a line-aligned address, one word-wide async read port.
module fq_line_ram
  import fetch_queue_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int LINE_WORDS  = DEF_LINE_WORDS,
  parameter int DEPTH_WORDS = DEF_DEPTH_WORDS,
  localparam int OW    = ow_f(LINE_WORDS),
  localparam int AW    = pw_f(DEPTH_WORDS) - 1,
  localparam int LA    = AW - OW,
  localparam int LINES = DEPTH_WORDS / LINE_WORDS
) (
  input  logic                             clk,
  input  logic                             we,
  input  logic [LA-1:0]                    wline,
  input  logic [LINE_WORDS*DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]                    raddr,
  output logic [DATA_WIDTH-1:0]            rdata
);

  typedef logic [LINE_WORDS-1:0][DATA_WIDTH-1:0] row_t;

  row_t mem [LINES];

  // NOTE: storage has no reset; the queue pointers alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (we) mem[wline] <= wdata;
  end

  assign rdata = mem[raddr[AW-1:OW]][raddr[OW-1:0]];

endmodule

// File: rtl/fetch_queue_lw.sv
// Fetch queue: accepts whole cache lines, hands out single words FWFT-style, with flush-and-skip redirect.
module fetch_queue_lw
  import fetch_queue_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int LINE_WORDS  = DEF_LINE_WORDS,
  parameter int DEPTH_WORDS = DEF_DEPTH_WORDS,
  parameter int AFULL_LINES = 1,
  localparam int OW = ow_f(LINE_WORDS),
  localparam int PW = pw_f(DEPTH_WORDS)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             flush,
  input  logic [OW-1:0]                    offset,
  input  logic                             push_valid,
  output logic                             push_ready,
  input  logic [LINE_WORDS*DATA_WIDTH-1:0] push_data,
  output logic                             pop_valid,
  input  logic                             pop_ready,
  output logic [DATA_WIDTH-1:0]            pop_data,
  output logic [PW-1:0]                    count,
  output logic                             almost_full,
  output logic [PW-1:0]                    wp,
  output logic [PW-1:0]                    rp
);

  localparam logic [PW-1:0] DEPTH_P   = PW'(DEPTH_WORDS);
  localparam logic [PW-1:0] LINE_P    = PW'(LINE_WORDS);
  localparam logic [31:0]   AFULL_THR = 32'((AFULL_LINES + 1) * LINE_WORDS);

  logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [OW-1:0] skip_q, skip_d;
  logic          skip_pend_q, skip_pend_d;
  logic [PW-1:0] count_w, free_w;
  logic          push_fire, pop_fire;

  // Every flag below depends only on registered pointers, never on this cycle's handshakes.
  assign count_w     = wp_q - rp_q;
  assign free_w      = DEPTH_P - count_w;
  assign push_ready  = (free_w >= LINE_P);
  assign pop_valid   = (count_w != '0);
  assign almost_full = (32'(free_w) < AFULL_THR);

  assign push_fire = push_valid && push_ready && !flush;
  assign pop_fire  = pop_valid && pop_ready && !flush;

  // NOTE: every signal gets its hold value first so no path through this block infers a latch.
  always_comb begin
    wp_d        = wp_q;
    rp_d        = rp_q;
    skip_d      = skip_q;
    skip_pend_d = skip_pend_q;
    if (flush) begin
      wp_d        = '0;
      rp_d        = '0;
      skip_d      = offset;
      skip_pend_d = 1'b1;
    end else begin
      if (push_fire) begin
        wp_d        = wp_q + LINE_P;
        skip_pend_d = 1'b0;
      end
      // The skip lands on the same edge as the first post-flush line; the queue is empty then, so no pop overlaps it.
      rp_d = rp_q + PW'(pop_fire) + ((push_fire && skip_pend_q) ? PW'(skip_q) : '0);
    end
  end

  // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wp_q        <= '0;
      rp_q        <= '0;
      skip_q      <= '0;
      skip_pend_q <= 1'b0;
    end else begin
      wp_q        <= wp_d;
      rp_q        <= rp_d;
      skip_q      <= skip_d;
      skip_pend_q <= skip_pend_d;
    end
  end

  fq_line_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .LINE_WORDS (LINE_WORDS),
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_ram (
    .clk  (clk),
    .we   (push_fire),
    .wline(wp_q[PW-2:OW]),
    .wdata(push_data),
    .raddr(rp_q[PW-2:0]),
    .rdata(pop_data)
  );

  assign count = count_w;
  assign wp    = wp_q;
  assign rp    = rp_q;

endmodule

// File: tb/tb_fetch_queue_lw.sv
// Self-checking bench for fetch_queue_lw at default parameters, directed scenarios plus randomized traffic vs a word-queue model.
module tb_fetch_queue_lw;
  import fetch_queue_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic [1:0]  offset = '0;
  logic        push_valid = 1'b0;
  logic        push_ready;
  line_t       push_data = '0;
  logic        pop_valid;
  logic        pop_ready = 1'b0;
  logic [31:0] pop_data;
  logic [6:0]  count;
  logic        almost_full;
  logic [6:0]  wp;
  logic [6:0]  rp;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a plain word queue plus modular pointer counters.
  logic [31:0] q[$];
  int          wp_m = 0;
  int          rp_m = 0;
  int          skip_m = 0;
  bit          pend_m = 0;

  fetch_queue_lw dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .offset     (offset),
    .push_valid (push_valid),
    .push_ready (push_ready),
    .push_data  (push_data),
    .pop_valid  (pop_valid),
    .pop_ready  (pop_ready),
    .pop_data   (pop_data),
    .count      (count),
    .almost_full(almost_full),
    .wp         (wp),
    .rp         (rp)
  );

  always #5 clk = ~clk;

  function automatic line_t mk_line(input logic [31:0] base);
    line_t l;
    for (int w = 0; w < 4; w++) l[w] = base + 32'(w);
    return l;
  endfunction

  // Drives one cycle of stimulus, advances the model, and returns 1 ns after the edge.
  task automatic cycle(input logic pv, input line_t pd, input logic pr,
                       input logic fl, input logic [1:0] off, input logic rst);
    bit push_ok, pop_ok;
    reset = rst; flush = fl; offset = off;
    push_valid = pv; push_data = pd; pop_ready = pr;
    if (!rst) begin
      q.delete(); wp_m = 0; rp_m = 0; skip_m = 0; pend_m = 0;
    end else if (fl) begin
      q.delete(); wp_m = 0; rp_m = 0; skip_m = int'(off); pend_m = 1;
    end else begin
      push_ok = pv && (64 - q.size() >= 4);
      pop_ok  = pr && (q.size() > 0);
      if (pop_ok) begin
        void'(q.pop_front());
        rp_m = (rp_m + 1) % 128;
      end
      if (push_ok) begin
        for (int w = 0; w < 4; w++) q.push_back(pd[w]);
        wp_m = (wp_m + 4) % 128;
        if (pend_m) begin
          for (int s = 0; s < skip_m; s++) void'(q.pop_front());
          rp_m = (rp_m + skip_m) % 128;
          pend_m = 0;
        end
      end
    end
    @(posedge clk);
    #1;
    reset = 1'b1; flush = 1'b0; push_valid = 1'b0; pop_ready = 1'b0;
  endtask

  task automatic test_reset();
    cycle(0, '0, 0, 0, 2'd0, 0);
    n_checks++; if (wp !== 7'd0) begin n_fail++; $display("FAIL reset_wp: got %0d expected 0", wp); end
    n_checks++; if (rp !== 7'd0) begin n_fail++; $display("FAIL reset_rp: got %0d expected 0", rp); end
    n_checks++; if (count !== 7'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count); end
    n_checks++; if (pop_valid !== 1'b0) begin n_fail++; $display("FAIL reset_pop_valid: got %b expected 0", pop_valid); end
    n_checks++; if (push_ready !== 1'b1) begin n_fail++; $display("FAIL reset_push_ready: got %b expected 1", push_ready); end
    n_checks++; if (almost_full !== 1'b0) begin n_fail++; $display("FAIL reset_almost_full: got %b expected 0", almost_full); end
  endtask

  task automatic test_push_drain();
    logic [31:0] exp_w [8] = '{32'h10, 32'h11, 32'h12, 32'h13, 32'h20, 32'h21, 32'h22, 32'h23};
    cycle(1, mk_line(32'h10), 0, 0, 2'd0, 1);
    n_checks++; if (count !== 7'd4) begin n_fail++; $display("FAIL drain_count_a: got %0d expected 4", count); end
    cycle(1, mk_line(32'h20), 0, 0, 2'd0, 1);
    n_checks++; if (count !== 7'd8) begin n_fail++; $display("FAIL drain_count_b: got %0d expected 8", count); end
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (pop_valid !== 1'b1 || pop_data !== exp_w[i]) begin
        n_fail++; $display("FAIL drain_word%0d: got v=%b d=%h expected v=1 d=%h", i, pop_valid, pop_data, exp_w[i]);
      end
      cycle(0, '0, 1, 0, 2'd0, 1);
      n_checks++; if (count !== 7'(7 - i)) begin n_fail++; $display("FAIL drain_count%0d: got %0d expected %0d", i, count, 7 - i); end
    end
    n_checks++; if (pop_valid !== 1'b0) begin n_fail++; $display("FAIL drain_empty: got %b expected 0", pop_valid); end
  endtask

  task automatic test_flush_offset();
    cycle(0, '0, 0, 1, 2'd2, 1);
    n_checks++;
    if (count !== 7'd0 || pop_valid !== 1'b0 || push_ready !== 1'b1) begin
      n_fail++; $display("FAIL flush_state: got cnt=%0d v=%b rdy=%b expected cnt=0 v=0 rdy=1", count, pop_valid, push_ready);
    end
    cycle(1, mk_line(32'hA0), 0, 0, 2'd0, 1);
    n_checks++; if (count !== 7'd2) begin n_fail++; $display("FAIL skip_count: got %0d expected 2", count); end
    n_checks++; if (pop_data !== 32'hA2) begin n_fail++; $display("FAIL skip_word0: got %h expected a2", pop_data); end
    n_checks++; if (rp !== 7'd2) begin n_fail++; $display("FAIL skip_rp: got %0d expected 2", rp); end
    cycle(0, '0, 1, 0, 2'd0, 1);
    n_checks++; if (pop_data !== 32'hA3) begin n_fail++; $display("FAIL skip_word1: got %h expected a3", pop_data); end
    cycle(0, '0, 1, 0, 2'd0, 1);
    n_checks++; if (pop_valid !== 1'b0) begin n_fail++; $display("FAIL skip_empty: got %b expected 0", pop_valid); end
  endtask

  task automatic test_full();
    cycle(0, '0, 0, 0, 2'd0, 0);
    for (int k = 1; k <= 16; k++) begin
      cycle(1, mk_line(32'h100 + 32'(4 * (k - 1))), 0, 0, 2'd0, 1);
      n_checks++;
      if (count !== 7'(4 * k) || almost_full !== (k >= 15) || push_ready !== (k < 16)) begin
        n_fail++; $display("FAIL fill%0d: got cnt=%0d af=%b rdy=%b expected cnt=%0d af=%b rdy=%b",
                           k, count, almost_full, push_ready, 4 * k, k >= 15, k < 16);
      end
    end
    cycle(1, mk_line(32'hDEAD0), 0, 0, 2'd0, 1);
    n_checks++; if (wp !== 7'd64 || count !== 7'd64) begin n_fail++; $display("FAIL full_reject: got wp=%0d cnt=%0d expected 64 64", wp, count); end
    for (int i = 0; i < 3; i++) cycle(0, '0, 1, 0, 2'd0, 1);
    n_checks++; if (count !== 7'd61) begin n_fail++; $display("FAIL full_pop3: got %0d expected 61", count); end
    cycle(1, mk_line(32'h200), 1, 0, 2'd0, 1);
    n_checks++; if (count !== 7'd60 || wp !== 7'd64) begin n_fail++; $display("FAIL full_pushpop: got cnt=%0d wp=%0d expected 60 64", count, wp); end
    cycle(0, '0, 1, 0, 2'd0, 1);
    n_checks++; if (count !== 7'd59 || pop_data !== 32'h105) begin n_fail++; $display("FAIL full_pop59: got cnt=%0d d=%h expected 59 105", count, pop_data); end
    cycle(1, mk_line(32'h200), 0, 0, 2'd0, 1);
    n_checks++; if (count !== 7'd63 || wp !== 7'd68 || almost_full !== 1'b1) begin
      n_fail++; $display("FAIL full_push63: got cnt=%0d wp=%0d af=%b expected 63 68 1", count, wp, almost_full);
    end
  endtask

  task automatic test_flush_priority();
    cycle(0, '0, 0, 0, 2'd0, 0);
    cycle(1, mk_line(32'h300), 0, 0, 2'd0, 1);
    cycle(1, mk_line(32'h310), 0, 0, 2'd0, 1);
    n_checks++; if (count !== 7'd8) begin n_fail++; $display("FAIL prio_setup: got %0d expected 8", count); end
    cycle(1, mk_line(32'hEE0), 1, 1, 2'd0, 1);
    n_checks++;
    if (count !== 7'd0 || wp !== 7'd0 || rp !== 7'd0 || pop_valid !== 1'b0) begin
      n_fail++; $display("FAIL prio_flush: got cnt=%0d wp=%0d rp=%0d v=%b expected 0 0 0 0", count, wp, rp, pop_valid);
    end
    cycle(1, mk_line(32'hC0), 0, 0, 2'd0, 1);
    n_checks++; if (count !== 7'd4 || pop_data !== 32'hC0) begin n_fail++; $display("FAIL prio_after: got cnt=%0d d=%h expected 4 c0", count, pop_data); end
  endtask

  task automatic test_random();
    line_t l;
    cycle(0, '0, 0, 0, 2'd0, 0);
    for (int i = 0; i < 1000; i++) begin
      for (int w = 0; w < 4; w++) l[w] = $urandom;
      if (i == 500) cycle(1, l, 1, 0, 2'd0, 0);
      else cycle(($urandom_range(0, 9) < 3), l, ($urandom_range(0, 9) < 7),
                 ($urandom_range(0, 99) == 0), 2'($urandom), 1);
      n_checks++;
      if (count !== 7'(q.size()) || wp !== 7'(wp_m) || rp !== 7'(rp_m)) begin
        n_fail++; $display("FAIL rand_ptr@%0d: got cnt=%0d wp=%0d rp=%0d expected %0d %0d %0d", i, count, wp, rp, q.size(), wp_m, rp_m);
      end
      n_checks++;
      if (pop_valid !== (q.size() > 0) || push_ready !== (64 - q.size() >= 4) || almost_full !== (64 - q.size() < 8)) begin
        n_fail++; $display("FAIL rand_flags@%0d: got v=%b rdy=%b af=%b expected %b %b %b", i, pop_valid, push_ready,
                           almost_full, q.size() > 0, 64 - q.size() >= 4, 64 - q.size() < 8);
      end
      if (q.size() > 0) begin
        n_checks++;
        if (pop_data !== q[0]) begin n_fail++; $display("FAIL rand_data@%0d: got %h expected %h", i, pop_data, q[0]); end
      end
    end
  endtask

  initial begin
    #3;
    test_reset();
    test_push_drain();
    test_flush_offset();
    test_full();
    test_flush_priority();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_queue_lw.md
# fetch_queue_lw

Line-write / word-read fetch queue that sits between instruction-cache line fill and decode. The fetch side pushes one cache line of `LINE_WORDS` instructions per accepted transfer; decode pops one instruction per cycle through a first-word-fall-through valid/ready port. A flush empties the queue and latches a word offset. The offset is applied to the first line pushed after the flush, so that line is consumed starting at the redirect target rather than at word 0. The block adds line-granular writes, handshakes, occupancy and almost-full reporting to the single-word FIFO generation.

## Interface
Parameters:
- `DATA_WIDTH`, 32: bits per instruction word.
- `LINE_WORDS`, 4: words per pushed line; power of 2, ≥2.
- `DEPTH_WORDS`, 64: storage in words; power of 2, multiple of `LINE_WORDS`, ≥2·`LINE_WORDS`.
- `AFULL_LINES`, 1: `almost_full` asserts when free space < (`AFULL_LINES`+1)·`LINE_WORDS` words.

Widths used below: OW = log2(`LINE_WORDS`); PW = log2(`DEPTH_WORDS`)+1.

Ports:
- `clk` in 1: single clock. All state updates on the rising edge.
- `reset` in 1: synchronous, active-low.
- `flush` in 1: empty the queue and latch `offset`.
- `offset` in OW: word index at which to start reading the next line pushed after a flush.
- `push_valid` in 1: a line is presented on `push_data`.
- `push_ready` out 1: free space ≥ `LINE_WORDS` words.
- `push_data` in `LINE_WORDS`·`DATA_WIDTH`: the line; word 0 in the LSBs.
- `pop_valid` out 1: queue is not empty.
- `pop_ready` in 1: consumer takes `pop_data` this cycle.
- `pop_data` out `DATA_WIDTH`: word at the read pointer, combinational from storage.
- `count` out PW: occupied words, 0..`DEPTH_WORDS`.
- `almost_full` out 1: see `AFULL_LINES`.
- `wp`, `rp` out PW: word pointers, each with a wrap bit in the MSB.

## Operation
- Pointer rules:
  - `wp` and `rp` are word pointers, modulo 2^PW.
  - `count` = `wp` − `rp` (PW-bit modular subtraction).
  - Empty when `count`==0; `push_ready` = (`DEPTH_WORDS` − `count`) ≥ `LINE_WORDS`.
- Push accepted when `push_valid`&&`push_ready`:
  - all `LINE_WORDS` words are written at `wp`..`wp`+`LINE_WORDS`−1;
  - `wp` += `LINE_WORDS`.
  - Because `wp` only moves in whole lines, a line never straddles the storage wrap.
- Pop accepted when `pop_valid`&&`pop_ready`: `rp` += 1.
  - `pop_ready` while empty is ignored.
  - `push_valid` while not ready is ignored; no storage write occurs.
- Skip register `skip` (OW bits) plus flag `skip_pend`:
  - `flush` sets `wp`=`rp`=0, `skip`=`offset`, `skip_pend`=1.
  - On the first accepted push with `skip_pend`=1: `rp` += `skip` in the same edge as `wp` += `LINE_WORDS`, then `skip_pend` clears.
  - Resulting occupancy is `LINE_WORDS`−`offset`.
  - The queue is always empty while `skip_pend`=1, so no pop can coincide with the skip.
- Priority:
  - `flush` overrides push and pop in the same cycle. Neither is accepted, and no storage write occurs.
  - Simultaneous push and pop: both are accepted; `count` changes by `LINE_WORDS`−1.
- Storage contents are not reset or cleared by flush; only pointers define validity.

## Timing
- Reset (`reset`=0 at an edge) gives:
  - `wp`=`rp`=0, `count`=0, `skip`=0, `skip_pend`=0;
  - `pop_valid`=0, `push_ready`=1, `almost_full`=0;
  - `pop_data` undefined.
- Reset has priority over `flush` and handshakes. Reset mid-stream discards all contents.
- Push-to-pop latency is 1 cycle: a line accepted at edge N makes `pop_valid`=1 and valid `pop_data` after edge N.
- Pop advances `rp` at the edge; the next word appears combinationally after that edge.
- A flush asserted at edge N gives `pop_valid`=0, `count`=0, `push_ready`=1 after edge N.
- All outputs are functions of registered state only: no combinational path from `push_valid`/`pop_ready` to any output.

## Structure
- Package `fetch_queue_pkg` holds:
  - width helper functions for OW and PW;
  - a typedef for the line type (`LINE_WORDS`×`DATA_WIDTH` packed array).
- One sub-module, `fq_line_ram`: register array with a line-wide write port (line-aligned address) and a word-wide asynchronous read port.
- Pointers, skip logic and flags stay in `fetch_queue_lw`.

## Test plan
- Reset, then push lines A=[0x10,0x11,0x12,0x13] and B=[0x20..0x23], drain with `pop_ready`=1 → `pop_data` 0x10..0x13, 0x20..0x23 in order. `pop_valid` drops after 8 pops; `count` goes 4,8,…,0.
- Flush with `offset`=2, push [0xA0..0xA3] → next cycle `count`=2, `pop_data`=0xA2 then 0xA3, then empty.
- Defaults: push 16 lines with no pops → `push_ready`=0 at `count`=64; `almost_full`=1 from `count`=60; a 17th `push_valid` is ignored and `wp` stays at 64.
- At `count`=61, push and pop in the same cycle:
  - push is rejected (free space 3 < 4) and only the pop occurs, giving `count`=60;
  - a further pop gives `count`=59 and then a push is accepted.
- Flush in the same cycle as a push and a pop at `count`=8 → `count`=0, `wp`=`rp`=0, pushed data is never popped.
- Run 1000 cycles of random push/pop with pointer wrap-around, checking against a scoreboard. Pulse `reset`=0 mid-run → all outputs return to reset values next cycle.
